// File: rtl/phys_reg_file_if.sv
// rtl/phys_reg_file_if.sv - operand read, writeback and allocate signals of the physical register file
interface phys_reg_file_if #(
  parameter int NUM_PREGS = 128,
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 32
);
  logic                 read_alu_r1;
  logic                 read_alu_r2;
  logic                 read_b_r1;
  logic                 read_b_r2;
  logic                 read_lru_r1;
  logic                 read_lru_r2;

  logic [TAG_W-1:0]     target_alu_r1;
  logic [TAG_W-1:0]     target_alu_r2;
  logic [TAG_W-1:0]     target_b_r1;
  logic [TAG_W-1:0]     target_b_r2;
  logic [TAG_W-1:0]     target_lru_r1;
  logic [TAG_W-1:0]     target_lru_r2;

  logic [DATA_W-1:0]    alu_r1;
  logic [DATA_W-1:0]    alu_r2;
  logic [DATA_W-1:0]    b_r1;
  logic [DATA_W-1:0]    b_r2;
  logic [DATA_W-1:0]    lru_r1;
  logic [DATA_W-1:0]    lru_r2;

  logic                 alu_wr_en;
  logic                 b_wr_en;
  logic                 mem_wr_en;
  logic [TAG_W-1:0]     alu_wr_tag;
  logic [TAG_W-1:0]     b_wr_tag;
  logic [TAG_W-1:0]     mem_wr_tag;
  logic [DATA_W-1:0]    alu_wr_data;
  logic [DATA_W-1:0]    b_wr_data;
  logic [DATA_W-1:0]    mem_wr_data;

  logic                 alloc_en;
  logic [TAG_W-1:0]     alloc_tag;

  logic [NUM_PREGS-1:0] preg_ready;

  modport master (
    output read_alu_r1, read_alu_r2, read_b_r1, read_b_r2, read_lru_r1, read_lru_r2,
    output target_alu_r1, target_alu_r2, target_b_r1, target_b_r2, target_lru_r1, target_lru_r2,
    input  alu_r1, alu_r2, b_r1, b_r2, lru_r1, lru_r2,
    output alu_wr_en, b_wr_en, mem_wr_en,
    output alu_wr_tag, b_wr_tag, mem_wr_tag,
    output alu_wr_data, b_wr_data, mem_wr_data,
    output alloc_en, alloc_tag,
    input  preg_ready
  );

  modport slave (
    input  read_alu_r1, read_alu_r2, read_b_r1, read_b_r2, read_lru_r1, read_lru_r2,
    input  target_alu_r1, target_alu_r2, target_b_r1, target_b_r2, target_lru_r1, target_lru_r2,
    output alu_r1, alu_r2, b_r1, b_r2, lru_r1, lru_r2,
    input  alu_wr_en, b_wr_en, mem_wr_en,
    input  alu_wr_tag, b_wr_tag, mem_wr_tag,
    input  alu_wr_data, b_wr_data, mem_wr_data,
    input  alloc_en, alloc_tag,
    output preg_ready
  );
endinterface

// File: rtl/phys_reg_file.sv
// rtl/phys_reg_file.sv - physical register file with six registered read ports, three writeback ports
// and a ready scoreboard; p0 is hardwired zero and always ready.
module phys_reg_file #(
  parameter int NUM_PREGS = 128,
  parameter int TAG_W     = 7,
  parameter int DATA_W    = 32
) (
  input  logic          clk,
  input  logic          reset,
  phys_reg_file_if.slave rf
);
  localparam int NUM_RD = 6;

  logic [DATA_W-1:0]    regs [NUM_PREGS];
  logic [NUM_PREGS-1:0] ready;

  logic [NUM_RD-1:0]    rd_en;
  logic [TAG_W-1:0]     rd_tag  [NUM_RD];
  logic [DATA_W-1:0]    rd_next [NUM_RD];
  logic [DATA_W-1:0]    rd_q    [NUM_RD];

  logic                 alu_wr_ok;
  logic                 b_wr_ok;
  logic                 mem_wr_ok;
  logic                 alloc_ok;

  // Port index order: alu r1/r2, branch r1/r2, lsu r1/r2.
  assign rd_en = {rf.read_lru_r2, rf.read_lru_r1, rf.read_b_r2,
                  rf.read_b_r1,   rf.read_alu_r2, rf.read_alu_r1};

  always_comb begin
    rd_tag[0] = rf.target_alu_r1;
    rd_tag[1] = rf.target_alu_r2;
    rd_tag[2] = rf.target_b_r1;
    rd_tag[3] = rf.target_b_r2;
    rd_tag[4] = rf.target_lru_r1;
    rd_tag[5] = rf.target_lru_r2;
  end

  assign rf.alu_r1 = rd_q[0];
  assign rf.alu_r2 = rd_q[1];
  assign rf.b_r1   = rd_q[2];
  assign rf.b_r2   = rd_q[3];
  assign rf.lru_r1 = rd_q[4];
  assign rf.lru_r2 = rd_q[5];

  assign rf.preg_ready = ready;

  // Writes and allocations aimed at p0 are dropped here once, so nothing below special-cases it.
  assign alu_wr_ok = rf.alu_wr_en && (rf.alu_wr_tag != '0);
  assign b_wr_ok   = rf.b_wr_en   && (rf.b_wr_tag   != '0);
  assign mem_wr_ok = rf.mem_wr_en && (rf.mem_wr_tag != '0);
  assign alloc_ok  = rf.alloc_en  && (rf.alloc_tag  != '0);

  // Bypass uses the same mem > b > alu priority as the array update.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_next[p] = regs[rd_tag[p]];
      if (rd_tag[p] == '0) begin
        rd_next[p] = '0;
      end else if (mem_wr_ok && (rf.mem_wr_tag == rd_tag[p])) begin
        rd_next[p] = rf.mem_wr_data;
      end else if (b_wr_ok && (rf.b_wr_tag == rd_tag[p])) begin
        rd_next[p] = rf.b_wr_data;
      end else if (alu_wr_ok && (rf.alu_wr_tag == rd_tag[p])) begin
        rd_next[p] = rf.alu_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_RD; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_q[p] <= rd_next[p];
        end
      end
    end
  end

  // Later non-blocking assignments win, which gives mem > b > alu on a tag collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (alu_wr_ok) begin
        regs[rf.alu_wr_tag] <= rf.alu_wr_data;
      end
      if (b_wr_ok) begin
        regs[rf.b_wr_tag] <= rf.b_wr_data;
      end
      if (mem_wr_ok) begin
        regs[rf.mem_wr_tag] <= rf.mem_wr_data;
      end
    end
  end

  // Allocation is applied after the writeback sets so it wins the ready bit on a same-tag overlap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= '1;
    end else begin
      if (alu_wr_ok) begin
        ready[rf.alu_wr_tag] <= 1'b1;
      end
      if (b_wr_ok) begin
        ready[rf.b_wr_tag] <= 1'b1;
      end
      if (mem_wr_ok) begin
        ready[rf.mem_wr_tag] <= 1'b1;
      end
      if (alloc_ok) begin
        ready[rf.alloc_tag] <= 1'b0;
      end
      ready[0] <= 1'b1;
    end
  end
endmodule

// File: doc/phys_reg_file.md
# phys_reg_file

Physical register file for the out-of-order core. It answers the six operand read requests that the issue stage raises each cycle: ALU r1/r2, branch r1/r2 and LSU r1/r2, each an enable plus a 7-bit physical tag. It also accepts three writeback ports from the functional units and keeps a per-register ready scoreboard that rename clears on allocation and writeback sets. It sits between the issue/operand-select logic and the FUs, and feeds the reservation-station wakeup logic.

## Interface
- NUM_PREGS, 128, number of physical registers; p0 is hardwired zero.
- TAG_W, 7, physical tag width; equals log2(NUM_PREGS).
- DATA_W, 32, register data width.

- clk  in  1  single core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- read_alu_r1, read_alu_r2, read_b_r1, read_b_r2, read_lru_r1, read_lru_r2  in  1 each  read enables.
- target_alu_r1, target_alu_r2, target_b_r1, target_b_r2, target_lru_r1, target_lru_r2  in  TAG_W each  read tags.
- alu_r1, alu_r2, b_r1, b_r2, lru_r1, lru_r2  out  DATA_W each  registered read data.
- alu_wr_en, b_wr_en, mem_wr_en  in  1 each  writeback enables.
- alu_wr_tag, b_wr_tag, mem_wr_tag  in  TAG_W each  writeback tags.
- alu_wr_data, b_wr_data, mem_wr_data  in  DATA_W each  writeback data.
- alloc_en  in  1  rename allocates a new destination this cycle.
- alloc_tag  in  TAG_W  tag being allocated.
- preg_ready  out  NUM_PREGS  registered scoreboard; bit i = 1 means pi holds valid data.

## Operation
- Storage: NUM_PREGS x DATA_W array plus a NUM_PREGS-bit ready vector.
- Reads: on a clock edge with the port's read enable high, the port's output register loads the array entry selected by its target. With the enable low, the output register holds its previous value.
- Write-first bypass: if a read tag matches a writeback tag that is active in the same cycle, the output loads that write data, not the stale array value.
- p0:
  - Reads of tag 0 return 0.
  - Writes to tag 0 are dropped.
  - Allocation of tag 0 is ignored.
  - preg_ready[0] is always 1.
- Writes: each active port writes its data at the clock edge and sets preg_ready[tag] = 1.
- Same-tag write collision: the highest-priority port wins, in the order mem > b > alu. This case is illegal upstream; the bench flags it with an assertion.
- Allocation: alloc_en clears preg_ready[alloc_tag] at the edge. Data is untouched.
- Alloc and write to the same tag in the same cycle: the data is written, and the alloc wins the ready bit (ready ends at 0).
- Read ports are independent. All six may hit the same tag, or the same tag being written, in one cycle.

## Timing
- Read latency is 1 cycle: data driven at edge N+1 for a request sampled at edge N. It is valid for the FU in cycle N+1.
- Write-to-read latency:
  - Same-cycle read of the written tag returns the new data via bypass, at N+1.
  - A later read returns it from the array.
- Write-to-ready: preg_ready rises in the cycle after the write edge. There is no combinational ready bypass.
- Alloc-to-ready: preg_ready falls in the cycle after the alloc edge.
- Reset (asynchronous, any time, including mid-operation):
  - All six data outputs go to 0.
  - All array entries go to 0.
  - preg_ready goes to all ones.
  - Requests pending in the reset cycle are discarded.
- After reset deasserts, the first edge with enables behaves normally. No warm-up cycles.

## Test plan
- Reset then read: assert reset, release; read_alu_r1=1, target_alu_r1=5 -> alu_r1=0 next cycle; preg_ready = all ones.
- Write then read with hold:
  - alu_wr_en, tag 9, data 0xDEADBEEF at edge N.
  - read_b_r2 tag 9 at N+1 -> b_r2=0xDEADBEEF at N+2.
  - Drop read_b_r2 -> b_r2 holds 0xDEADBEEF.
- Bypass and p0:
  - mem_wr tag 12, data 0x1234 and read_lru_r1 tag 12 in the same cycle -> lru_r1=0x1234 next cycle.
  - b_wr tag 0, data 0xFFFF, then read tag 0 -> 0; preg_ready[0] stays 1.
- Scoreboard:
  - alloc tag 40 -> preg_ready[40]=0 next cycle.
  - alu_wr tag 40 two cycles later -> preg_ready[40]=1 the cycle after.
  - Alloc and b_wr on tag 41 in the same cycle -> preg_ready[41]=0 and data written.
- Priority and mid-operation reset:
  - alu_wr and mem_wr both tag 7, data 0x1 and 0x2 -> read tag 7 = 0x2.
  - Next, assert reset asynchronously between edges while six reads are active -> all outputs go to 0 immediately; read of tag 7 after release = 0.
